alu_result_nibble_display: RTL and testbench

Sequential display driver for the board-level test harness of the RISC-V core. It captures a 32-bit ALU result and shows it on the four LED outputs one nibble at a time. Nibbles appear most-significant first, each held for a programmable dwell and separated by a blank gap. It is the output counterpart of the switch-driven instruction input path, so the whole `ALUOut`, not just bits [3:0], can be read on the board.

---
 rtl/alu_result_nibble_display_if.sv | 20 ++
 rtl/alu_result_nibble_display.sv | 118 +++++++++++
 tb/tb_alu_result_nibble_display.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_nibble_display_if.sv
// Load handshake and LED display bundle for the ALU result nibble display.
interface alu_result_nibble_display_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] result;
  logic [3:0]  leds;
  logic [2:0]  nib_idx;
  logic        busy;
  logic        done;

  modport master (
    output load_valid, result,
    input  load_ready, leds, nib_idx, busy, done
  );

  modport slave (
    input  load_valid, result,
    output load_ready, leds, nib_idx, busy, done
  );
endinterface

// File: rtl/alu_result_nibble_display.sv
// Shows a captured 32-bit ALU result on four LEDs, one nibble at a time,
// MSB nibble first, with a blank gap after every nibble.
module alu_result_nibble_display #(
  parameter int DWELL_CYCLES = 25_000_000,
  parameter int GAP_CYCLES   = 2_500_000,
  parameter int REPEAT       = 0
) (
  input logic                          clk,
  input logic                          rst,
  alu_result_nibble_display_if.slave   bus
);

  localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ?
                        DWELL_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DW_LD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] GP_LD = CW'(GAP_CYCLES - 1);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] SHOW = 2'b01;
  localparam logic [1:0] GAP  = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hold_q, hold_d;
  logic [3:0]    leds_q, leds_d;
  logic [2:0]    nib_idx_q, nib_idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          accept;

  assign bus.load_ready = (state_q == IDLE) ||
                          ((state_q == GAP) && (REPEAT == 1));
  assign accept = bus.load_valid && bus.load_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (accept) begin
      hold_d  = bus.result;
      idx_d   = 3'd7;
      cnt_d   = DW_LD;
      state_d = SHOW;
    end else begin
      unique case (1'b1)
        (state_q == SHOW): begin
          if (cnt_q == '0) begin
            cnt_d   = GP_LD;
            state_d = GAP;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        (state_q == GAP): begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else if (idx_q != 3'd0) begin
            idx_d   = idx_q - 3'd1;
            cnt_d   = DW_LD;
            state_d = SHOW;
          end else begin
            done_d = 1'b1;
            if (REPEAT == 1) begin
              idx_d   = 3'd7;
              cnt_d   = DW_LD;
              state_d = SHOW;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered from the next state so they move with it.
  always_comb begin
    leds_d    = '0;
    nib_idx_d = '0;
    busy_d    = (state_d != IDLE);
    if (state_d == SHOW) leds_d = hold_d[{idx_d, 2'b00} +: 4];
    if (state_d != IDLE) nib_idx_d = idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      leds_q    <= '0;
      nib_idx_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      leds_q    <= leds_d;
      nib_idx_q <= nib_idx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.leds    = leds_q;
  assign bus.nib_idx = nib_idx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_alu_result_nibble_display.sv
// Bench for alu_result_nibble_display: one-pass and looping instances
// checked cycle by cycle against an arithmetic display-timeline model.
module tb_alu_result_nibble_display;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  alu_result_nibble_display_if if0 ();
  alu_result_nibble_display_if if1 ();

  alu_result_nibble_display #(
    .DWELL_CYCLES(4), .GAP_CYCLES(2), .REPEAT(0)
  ) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  alu_result_nibble_display #(
    .DWELL_CYCLES(4), .GAP_CYCLES(2), .REPEAT(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {leds, nib_idx, busy, done} k cycles after the first SHOW cycle.
  function automatic logic [8:0] exp_vec(input logic [31:0] v,
                                         input int k, input bit rep);
    int p, n, w;
    logic [31:0] sh;
    logic [3:0]  l;
    logic        d;
    if (!rep && k >= 48) return {4'h0, 3'd0, 1'b0, (k == 48)};
    p  = k % 48;
    n  = p / 6;
    w  = p % 6;
    sh = v >> (4 * (7 - n));
    l  = (w < 4) ? sh[3:0] : 4'h0;
    d  = (k > 0) && (p == 0);
    return {l, 3'(7 - n), 1'b1, d};
  endfunction

  function automatic logic [8:0] obs0();
    return {if0.leds, if0.nib_idx, if0.busy, if0.done};
  endfunction

  function automatic logic [8:0] obs1();
    return {if1.leds, if1.nib_idx, if1.busy, if1.done};
  endfunction

  task automatic do_load(input bit sel, input logic [31:0] v);
    if (sel) begin
      if1.load_valid = 1'b1; if1.result = v;
    end else begin
      if0.load_valid = 1'b1; if0.result = v;
    end
    @(posedge clk); #1;
    if0.load_valid = 1'b0;
    if1.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (obs0() !== 9'h0) begin
      tests_failed++;
      $display("FAIL reset_out0 got=%h exp=%h", obs0(), 9'h0);
    end
    tests_run++;
    if (obs1() !== 9'h0) begin
      tests_failed++;
      $display("FAIL reset_out1 got=%h exp=%h", obs1(), 9'h0);
    end
    tests_run++;
    if (if0.load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready got=%b exp=1", if0.load_ready);
    end
  endtask

  task automatic test_single_pass(input logic [31:0] v);
    logic [8:0] e;
    do_load(1'b0, v);
    for (int k = 0; k <= 52; k++) begin
      e = exp_vec(v, k, 1'b0);
      tests_run++;
      if (obs0() !== e) begin
        tests_failed++;
        $display("FAIL single_pass v=%h k=%0d got=%h exp=%h",
                 v, k, obs0(), e);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (if0.load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL pass_end_ready got=%b exp=1", if0.load_ready);
    end
  endtask

  task automatic test_repeated_nibbles();
    logic [31:0] vals [2];
    logic [8:0]  e;
    vals[0] = 32'h00000000;
    vals[1] = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      do_load(1'b0, vals[i]);
      for (int k = 0; k <= 48; k++) begin
        e = exp_vec(vals[i], k, 1'b0);
        tests_run++;
        if (obs0() !== e) begin
          tests_failed++;
          $display("FAIL repeated_nib v=%h k=%0d got=%h exp=%h",
                   vals[i], k, obs0(), e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_ignored_load(input logic [31:0] v, input int kp,
                                   input logic [31:0] junk);
    logic [8:0] e;
    do_load(1'b0, v);
    for (int k = 0; k <= 49; k++) begin
      e = exp_vec(v, k, 1'b0);
      tests_run++;
      if (obs0() !== e) begin
        tests_failed++;
        $display("FAIL ignored_load v=%h k=%0d got=%h exp=%h",
                 v, k, obs0(), e);
      end
      if (k == kp) begin
        tests_run++;
        if (if0.load_ready !== 1'b0) begin
          tests_failed++;
          $display("FAIL busy_ready k=%0d got=%b exp=0", k, if0.load_ready);
        end
        if0.load_valid = 1'b1;
        if0.result     = junk;
      end else begin
        if0.load_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    if0.load_valid = 1'b0;
  endtask

  task automatic test_repeat();
    logic [8:0]  e;
    logic [31:0] v;
    v = 32'h8765_4321;
    do_load(1'b1, v);
    for (int k = 0; k <= 106; k++) begin
      e = exp_vec(v, k, 1'b1);
      tests_run++;
      if (obs1() !== e) begin
        tests_failed++;
        $display("FAIL repeat k=%0d got=%h exp=%h", k, obs1(), e);
      end
      if (k < 106) begin
        @(posedge clk); #1;
      end
    end
    tests_run++;
    if (if1.load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL gap_ready got=%b exp=1", if1.load_ready);
    end
    v = 32'hCAFEF00D;
    do_load(1'b1, v);
    for (int k = 0; k <= 50; k++) begin
      e = exp_vec(v, k, 1'b1);
      tests_run++;
      if (obs1() !== e) begin
        tests_failed++;
        $display("FAIL repeat_reload k=%0d got=%h exp=%h", k, obs1(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_pass();
    logic [8:0] e;
    do_load(1'b0, 32'h1234ABCD);
    repeat (19) @(posedge clk);
    #1;
    e = exp_vec(32'h1234ABCD, 19, 1'b0);
    tests_run++;
    if (obs0() !== e) begin
      tests_failed++;
      $display("FAIL mid_pass_pre got=%h exp=%h", obs0(), e);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests_run++;
    if (obs0() !== 9'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_out0 got=%h exp=%h", obs0(), 9'h0);
    end
    tests_run++;
    if (obs1() !== 9'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_out1 got=%h exp=%h", obs1(), 9'h0);
    end
    tests_run++;
    if (if0.load_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_ready got=%b exp=1", if0.load_ready);
    end
    do_load(1'b0, 32'h1234ABCD);
    for (int k = 0; k <= 49; k++) begin
      e = exp_vec(32'h1234ABCD, k, 1'b0);
      tests_run++;
      if (obs0() !== e) begin
        tests_failed++;
        $display("FAIL after_reset k=%0d got=%h exp=%h", k, obs0(), e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      test_ignored_load($urandom, int'($urandom_range(0, 47)), $urandom);
    end
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    rst            = 1'b1;
    if0.load_valid = 1'b0;
    if0.result     = '0;
    if1.load_valid = 1'b0;
    if1.result     = '0;
    test_reset();
    test_single_pass(32'h1234ABCD);
    test_repeated_nibbles();
    test_ignored_load(32'h1234ABCD, 1, 32'hDEADBEEF);
    test_repeat();
    test_reset_mid_pass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
